// File: rtl/sort_pkg.sv
// Shared types and defaults for the sorter frame loader.
// Default geometry and bank state encoding.
package sort_pkg;

    localparam int SORT_N = 6;
    localparam int SORT_WIDTH = 8;
    localparam logic [SORT_WIDTH-1:0] SORT_PAD = {SORT_WIDTH{1'b1}};
    localparam int CNT_W = $clog2(SORT_N + 1);

    typedef logic [SORT_WIDTH-1:0] sample_t;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } bank_state_t;

endpackage

// File: rtl/sort_frame_bank.sv
// One frame buffer: N-slot storage, close count and fill state.
// Slots past the recorded count read back as the pad value.
module sort_frame_bank
    import sort_pkg::*;
#(
    parameter int N = SORT_N,
    parameter int WIDTH = SORT_WIDTH,
    parameter logic [WIDTH-1:0] PAD_VALUE = {WIDTH{1'b1}},
    localparam int IW = (N > 1) ? $clog2(N) : 1,
    localparam int CW = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [IW-1:0]    i_wr_idx,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_close,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data [N],
    output logic [CW-1:0]    o_count,
    output logic             o_full
);

    bank_state_t      r_state;
    bank_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_mem [N];
    logic [CW-1:0]    r_count;

    always_comb begin
        w_state_nxt = r_state;
        if (i_pop) begin
            w_state_nxt = EMPTY;
        end
        if (i_wr_en) begin
            w_state_nxt = i_close ? FULL : FILLING;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            for (int i = 0; i < N; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
            if (i_close) begin
                r_count <= CW'(i_wr_idx) + CW'(1);
            end
        end
    end

    // Padding applies only to a closed frame; stale slots are never exposed as data.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            o_data[i] = r_mem[i];
            if (r_state == FULL && CW'(i) >= r_count) begin
                o_data[i] = PAD_VALUE;
            end
        end
    end

    assign o_count = r_count;
    assign o_full  = (r_state == FULL);

endmodule

// File: rtl/sort_frame_loader.sv
// Packs a serial sample stream into double-buffered N-slot frames
// and hands one stable, padded frame at a time to the sorter.
module sort_frame_loader
    import sort_pkg::*;
#(
    parameter int N = SORT_N,
    parameter int WIDTH = SORT_WIDTH,
    parameter logic [WIDTH-1:0] PAD_VALUE = {WIDTH{1'b1}},
    localparam int IW = (N > 1) ? $clog2(N) : 1,
    localparam int CW = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] frame_data [N],
    output logic [CW-1:0]    frame_count,
    output logic             frame_valid,
    input  logic             frame_ready
);

    logic             r_wr_bank;
    logic             r_rd_bank;
    logic             r_in_ready;
    logic [IW-1:0]    r_wr_idx;
    logic [1:0]       w_full;
    logic [1:0]       w_full_nxt;
    logic             w_accept;
    logic             w_close;
    logic             w_pop;
    logic             w_wr_bank_nxt;
    logic [WIDTH-1:0] w_bank_data [2][N];
    logic [CW-1:0]    w_bank_count [2];

    assign w_accept = in_valid && r_in_ready;
    assign w_close  = w_accept && (in_last || r_wr_idx == IW'(N - 1));
    assign w_pop    = frame_valid && frame_ready;
    assign w_wr_bank_nxt = r_wr_bank ^ w_close;

    for (genvar g = 0; g < 2; g++) begin : g_bank
        sort_frame_bank #(
            .N         (N),
            .WIDTH     (WIDTH),
            .PAD_VALUE (PAD_VALUE)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .i_wr_en   (w_accept && r_wr_bank == 1'(g)),
            .i_wr_idx  (r_wr_idx),
            .i_wr_data (in_data),
            .i_close   (w_close),
            .i_pop     (w_pop && r_rd_bank == 1'(g)),
            .o_data    (w_bank_data[g]),
            .o_count   (w_bank_count[g]),
            .o_full    (w_full[g])
        );
    end

    // Post-edge fullness, so in_ready is a plain flop with no path from frame_ready.
    always_comb begin
        w_full_nxt = w_full;
        if (w_pop) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
        if (w_close) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_wr_idx   <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_wr_bank  <= w_wr_bank_nxt;
            r_rd_bank  <= r_rd_bank ^ w_pop;
            r_in_ready <= !w_full_nxt[w_wr_bank_nxt];
            if (w_close) begin
                r_wr_idx <= '0;
            end else if (w_accept) begin
                r_wr_idx <= r_wr_idx + IW'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            frame_data[i] = w_bank_data[r_rd_bank][i];
        end
    end

    assign frame_count = w_bank_count[r_rd_bank];
    assign frame_valid = w_full[r_rd_bank];
    assign in_ready    = r_in_ready;

endmodule

// File: tb/tb_sort_frame_loader.sv
// Directed and random stimulus for sort_frame_loader, checked against
// a queue-of-frames reference model.
module tb_sort_frame_loader;
    import sort_pkg::*;

    localparam int N = SORT_N;

    typedef struct {
        logic [7:0] s [N];
        int         cnt;
    } frame_t;

    logic             clk = 1'b0;
    logic             rst;
    sample_t          in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    sample_t          frame_data [N];
    logic [CNT_W-1:0] frame_count;
    logic             frame_valid;
    logic             frame_ready;

    int         n_chk = 0;
    int         n_fail = 0;
    frame_t     q [$];
    logic [7:0] cur [$];
    bit         live = 0;
    bit         acc_last = 0;

    sort_frame_loader dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .frame_data  (frame_data),
        .frame_count (frame_count),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] e [N],
                               input int c);
        chk({tag, "_valid"}, frame_valid, 1);
        chk({tag, "_count"}, frame_count, c);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_slot%0d", tag, i), frame_data[i], e[i]);
        end
    endtask

    // One clock: check outputs against the model, then advance the model.
    task automatic cycle(input logic v, input logic [7:0] d,
                         input logic l, input logic fr);
        bit     exp_valid;
        bit     pop;
        frame_t f;
        in_valid = v;
        in_data = d;
        in_last = l;
        frame_ready = fr;
        #1;
        exp_valid = (q.size() > 0);
        chk("frame_valid", frame_valid, exp_valid);
        if (live) chk("in_ready", in_ready, q.size() < 2);
        if (exp_valid) begin
            chk("m_count", frame_count, q[0].cnt);
            for (int i = 0; i < N; i++) begin
                chk($sformatf("m_slot%0d", i), frame_data[i], q[0].s[i]);
            end
        end
        acc_last = v && live && (q.size() < 2);
        pop = exp_valid && fr;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (acc_last) begin
            cur.push_back(d);
            if (cur.size() == N || l) begin
                f.cnt = cur.size();
                for (int i = 0; i < N; i++) begin
                    f.s[i] = (i < cur.size()) ? cur[i] : 8'hFF;
                end
                q.push_back(f);
                cur.delete();
            end
        end
        live = 1;
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        cur.delete();
        live = 0;
    endtask

    initial begin
        logic [7:0] e [N];
        int         s;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        frame_ready = 1'b0;
        #3;
        chk("rst_valid", frame_valid, 0);
        chk("rst_count", frame_count, 0);
        chk("rst_in_ready", in_ready, 0);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst_slot%0d", i), frame_data[i], 0);
        end
        #4;
        rst = 1'b0;
        cycle(0, 0, 0, 1);
        chk("in_ready_after_rst", in_ready, 1);

        e = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd7, 8'd2};
        for (int i = 0; i < N; i++) cycle(1, e[i], 0, 1);
        check_frame("basic", e, 6);
        cycle(0, 0, 0, 1);
        chk("basic_popped", frame_valid, 0);

        s = 0;
        for (int c = 0; c < 16 && s < 14; c++) begin
            cycle(1, 8'(s), 0, 0);
            if (acc_last) s++;
        end
        chk("stall_in_ready", in_ready, 0);
        e = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        check_frame("stall_f0", e, 6);
        for (int c = 0; c < 10 && s < 14; c++) begin
            cycle(1, 8'(s), 0, 1);
            if (acc_last) s++;
        end
        cycle(1, 8'd14, 1, 0);
        for (int c = 0; c < 4; c++) cycle(0, 0, 0, 1);

        cycle(1, 8'd4, 0, 0);
        cycle(1, 8'd8, 0, 0);
        cycle(1, 8'd1, 1, 0);
        e = '{8'd4, 8'd8, 8'd1, 8'hFF, 8'hFF, 8'hFF};
        check_frame("short3", e, 3);
        cycle(0, 0, 0, 1);

        cycle(1, 8'h10, 1, 0);
        for (int i = 0; i < N; i++) cycle(1, 8'(8'h20 + i), 0, 0);
        e = '{8'h10, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        check_frame("short1", e, 1);
        cycle(0, 0, 0, 1);
        e = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
        check_frame("after_short1", e, 6);
        cycle(0, 0, 0, 1);

        for (int i = 0; i < N; i++) cycle(1, 8'(8'h30 + i), 0, 0);
        for (int i = 0; i < N - 1; i++) cycle(1, 8'(8'h40 + i), 0, 0);
        cycle(1, 8'h45, 0, 1);
        e = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        check_frame("close_pop", e, 6);
        chk("close_pop_in_ready", in_ready, 1);
        cycle(0, 0, 0, 1);

        for (int i = 0; i < N + 4; i++) cycle(1, 8'(8'h50 + i), 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", frame_valid, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_count", frame_count, 0);
        model_reset();
        #2;
        rst = 1'b0;
        cycle(0, 0, 0, 0);
        for (int i = 0; i < N; i++) cycle(1, 8'(8'h60 + i), 0, 0);
        e = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        check_frame("post_rst", e, 6);
        cycle(0, 0, 0, 1);

        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
        end
        for (int c = 0; c < 6; c++) cycle(0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
